// File: rtl/dbg_pkg.sv
// Shared types and address constants for the debug register writer.
// The VERIFY state exists only when DBG_WR_VERIFY_EN is defined.
package dbg_pkg;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_CTL = 2'b11;

  localparam logic [3:0] RS_TESTA = 4'b0100;
  localparam logic [3:0] RS_PC    = 4'b1110;
  localparam logic [3:0] RS_IR    = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALF,
    ST_FULL,
    ST_PEND
`ifdef DBG_WR_VERIFY_EN
    , ST_VERIFY
`endif
  } state_t;

  // One bit per writable target; at most one bit is ever set.
  typedef struct packed {
    logic rf;
    logic testa;
    logic pc;
    logic ir;
  } strb_t;

endpackage

// File: rtl/dbg_addr_decode.sv
// dbg_addr_decode: maps the readout address {sel,reg_sel} onto a one-hot write target.
// Latency: combinational. Backpressure: none.
module dbg_addr_decode
  import dbg_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [3:0] reg_sel,
  output strb_t      strb,
  output logic       valid
);

  always_comb begin
    strb = '0;
    case (sel)
      SEL_RF:  strb.rf = 1'b1;
      SEL_ALU: strb.testa = (reg_sel == RS_TESTA);
      SEL_CTL: begin
        strb.pc = (reg_sel == RS_PC);
        strb.ir = (reg_sel == RS_IR);
      end
      default: strb = '0;
    endcase
    // Offset, alu_a/b, alu_out and unused slots decode to nothing and are rejected.
    valid = |strb;
  end

endmodule

// File: rtl/dbg_reg_writer.sv
// dbg_reg_writer: builds a word from two switch loads, then strobes exactly one CPU state target (readback check under DBG_WR_VERIFY_EN).
// Latency: strobe is high the cycle after PEND samples cpu_busy=0; readback compare follows two cycles later.
// Backpressure: cpu_busy holds the write in PEND; ld_byte and commit are ignored while busy.
module dbg_reg_writer
  import dbg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        sel,
  input  logic [3:0]        reg_sel,
  input  logic [BYTE_W-1:0] sw_data,
  input  logic              ld_byte,
  input  logic              commit,
  input  logic              abort,
  input  logic              cpu_busy,
  input  logic [DATA_W-1:0] reg_data,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        wr_addr,
  output logic              rf_we,
  output logic              testa_we,
  output logic              pc_we,
  output logic              ir_we,
  output logic              busy,
  output logic              err,
  output logic              verify_fail
);

  localparam int HI_W = DATA_W - BYTE_W;

  state_t state;
  strb_t  tgt;
  strb_t  strb;
  strb_t  dec_strb;
  logic   dec_valid;

  dbg_addr_decode u_dec (
    .sel     (sel),
    .reg_sel (reg_sel),
    .strb    (dec_strb),
    .valid   (dec_valid)
  );

`ifdef DBG_WR_VERIFY_EN
  logic vcnt;
  logic vfail;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wr_data <= '0;
      wr_addr <= '0;
      tgt     <= '0;
      strb    <= '0;
      err     <= 1'b0;
`ifdef DBG_WR_VERIFY_EN
      vcnt    <= 1'b0;
      vfail   <= 1'b0;
`endif
    end else begin
      strb <= '0;
      if (abort) begin
        state   <= ST_IDLE;
        wr_data <= '0;
        err     <= 1'b0;
`ifdef DBG_WR_VERIFY_EN
        vfail   <= 1'b0;
`endif
      end else begin
        // commit outranks ld_byte in every state that looks at either.
        case (state)
          ST_IDLE: begin
            if (commit) begin
              err <= 1'b1;
            end else if (ld_byte) begin
              wr_data[BYTE_W-1:0] <= sw_data;
              state               <= ST_HALF;
            end
          end
          ST_HALF: begin
            if (commit) begin
              err <= 1'b1;
            end else if (ld_byte) begin
              wr_data[DATA_W-1:BYTE_W] <= sw_data;
              state                    <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (commit) begin
              if (dec_valid) begin
                tgt     <= dec_strb;
                wr_addr <= reg_sel;
                state   <= ST_PEND;
`ifdef DBG_WR_VERIFY_EN
                vfail   <= 1'b0;
`endif
              end else begin
                err   <= 1'b1;
                state <= ST_IDLE;
              end
            end else if (ld_byte) begin
              wr_data <= {{HI_W{1'b0}}, sw_data};
              state   <= ST_HALF;
            end
          end
          ST_PEND: begin
            if (!cpu_busy) begin
              strb  <= tgt;
`ifdef DBG_WR_VERIFY_EN
              vcnt  <= 1'b0;
              state <= ST_VERIFY;
`else
              state <= ST_IDLE;
`endif
            end
          end
`ifdef DBG_WR_VERIFY_EN
          // Two cycles let the target latch the word and the readout mux settle.
          ST_VERIFY: begin
            if (!vcnt) begin
              vcnt <= 1'b1;
            end else begin
              if (reg_data != wr_data) vfail <= 1'b1;
              state <= ST_IDLE;
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rf_we    = strb.rf;
  assign testa_we = strb.testa;
  assign pc_we    = strb.pc;
  assign ir_we    = strb.ir;

`ifdef DBG_WR_VERIFY_EN
  assign busy        = (state == ST_PEND) || (state == ST_VERIFY);
  assign verify_fail = vfail;
`else
  logic unused_reg_data;
  assign unused_reg_data = ^reg_data;
  assign busy            = (state == ST_PEND);
  assign verify_fail     = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_reg_writer.sv
// Directed bench for dbg_reg_writer; expectations follow DBG_WR_VERIFY_EN when it is defined.
module tb_dbg_reg_writer;

`ifdef DBG_WR_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic [3:0]  reg_sel;
  logic [7:0]  sw_data;
  logic        ld_byte, commit, abort, cpu_busy;
  logic [15:0] reg_data;
  logic [15:0] wr_data;
  logic [3:0]  wr_addr;
  logic        rf_we, testa_we, pc_we, ir_we, busy, err, verify_fail;

  int tests = 0;
  int fails = 0;
  int cnt_rf, cnt_testa, cnt_pc, cnt_ir;

  always #5 clk = ~clk;

  dbg_reg_writer #(.DATA_W(16), .BYTE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .reg_sel(reg_sel), .sw_data(sw_data),
    .ld_byte(ld_byte), .commit(commit), .abort(abort), .cpu_busy(cpu_busy),
    .reg_data(reg_data), .wr_data(wr_data), .wr_addr(wr_addr), .rf_we(rf_we),
    .testa_we(testa_we), .pc_we(pc_we), .ir_we(ir_we), .busy(busy), .err(err),
    .verify_fail(verify_fail)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cnt_rf    += int'(rf_we);
    cnt_testa += int'(testa_we);
    cnt_pc    += int'(pc_we);
    cnt_ir    += int'(ir_we);
  endtask

  task automatic clr_cnt();
    cnt_rf = 0; cnt_testa = 0; cnt_pc = 0; cnt_ir = 0;
  endtask

  task automatic load(input logic [7:0] b);
    sw_data = b; ld_byte = 1'b1;
    step();
    ld_byte = 1'b0;
  endtask

  task automatic do_commit(input logic [1:0] s, input logic [3:0] r);
    sel = s; reg_sel = r; commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    tests++;
    if ({wr_data, wr_addr, rf_we, testa_we, pc_we, ir_we, busy, err, verify_fail} !== 27'd0) begin
      fails++; $display("FAIL reset_initial outputs=%h want 0",
        {wr_data, wr_addr, rf_we, testa_we, pc_we, ir_we, busy, err, verify_fail});
    end
    rst_n = 1'b1;
    step();
    load(8'h77);
    do_commit(2'b00, 4'h1);         // commit in HALF: err, stays HALF
    load(8'h88);                    // now FULL, word 0x8877
    tests++;
    if (wr_data !== 16'h8877 || err !== 1'b1) begin
      fails++; $display("FAIL reset_setup wr_data=%h err=%b want 8877/1", wr_data, err);
    end
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    tests++;
    if ({wr_data, wr_addr, rf_we, testa_we, pc_we, ir_we, busy, err, verify_fail} !== 27'd0) begin
      fails++; $display("FAIL reset_midfull outputs=%h want 0",
        {wr_data, wr_addr, rf_we, testa_we, pc_we, ir_we, busy, err, verify_fail});
    end
    load(8'hAB);
    tests++;
    if (wr_data !== 16'h00AB) begin
      fails++; $display("FAIL reset_low_byte wr_data=%h want 00ab", wr_data);
    end
    load(8'hCD);
    tests++;
    if (wr_data !== 16'hCDAB) begin
      fails++; $display("FAIL reset_high_byte wr_data=%h want cdab", wr_data);
    end
    do_abort();
  endtask

  task automatic test_rf_write();
    load(8'h34);
    load(8'h12);
    tests++;
    if (wr_data !== 16'h1234) begin
      fails++; $display("FAIL rf_assemble wr_data=%h want 1234", wr_data);
    end
    reg_data = 16'h1234; cpu_busy = 1'b0;
    clr_cnt();
    do_commit(2'b00, 4'b0101);
    tests++;
    if (busy !== 1'b1 || rf_we !== 1'b0) begin
      fails++; $display("FAIL rf_pend busy=%b rf_we=%b want 1/0", busy, rf_we);
    end
    sel = 2'b11; reg_sel = 4'hF;    // wiggling after commit must not matter
    step();
    tests++;
    if ({rf_we, testa_we, pc_we, ir_we} !== 4'b1000 || wr_addr !== 4'd5 || wr_data !== 16'h1234) begin
      fails++; $display("FAIL rf_strobe strobes=%b addr=%0d data=%h want 1000/5/1234",
        {rf_we, testa_we, pc_we, ir_we}, wr_addr, wr_data);
    end
    tests++;
    if (busy !== VERIFY_ON) begin
      fails++; $display("FAIL rf_busy_after busy=%b want %b", busy, VERIFY_ON);
    end
    step(); step(); step(); step();
    tests++;
    if (cnt_rf !== 1 || cnt_testa + cnt_pc + cnt_ir !== 0 || busy !== 1'b0) begin
      fails++; $display("FAIL rf_once rf=%0d other=%0d busy=%b want 1/0/0",
        cnt_rf, cnt_testa + cnt_pc + cnt_ir, busy);
    end
  endtask

  task automatic test_pc_wait();
    load(8'hEF);
    load(8'hBE);
    reg_data = 16'hBEEF; cpu_busy = 1'b1;
    clr_cnt();
    do_commit(2'b11, 4'b1110);
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (busy !== 1'b1 || cnt_pc !== 0) begin
        fails++; $display("FAIL pc_hold cyc=%0d busy=%b pc_cnt=%0d want 1/0", i, busy, cnt_pc);
      end
    end
    cpu_busy = 1'b0;
    step();
    tests++;
    if (pc_we !== 1'b1 || busy !== VERIFY_ON || wr_data !== 16'hBEEF) begin
      fails++; $display("FAIL pc_strobe pc_we=%b busy=%b data=%h want 1/%b/beef",
        pc_we, busy, wr_data, VERIFY_ON);
    end
    step(); step(); step(); step();
    tests++;
    if (cnt_pc !== 1 || cnt_rf + cnt_testa + cnt_ir !== 0) begin
      fails++; $display("FAIL pc_once pc=%0d other=%0d want 1/0", cnt_pc, cnt_rf + cnt_testa + cnt_ir);
    end
  endtask

  task automatic test_err();
    clr_cnt();
    load(8'h01);
    load(8'h02);
    do_commit(2'b01, 4'b0011);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL err_invalid err=%b busy=%b want 1/0", err, busy);
    end
    step(); step();
    tests++;
    if (cnt_rf + cnt_testa + cnt_pc + cnt_ir !== 0) begin
      fails++; $display("FAIL err_nostrobe strobes=%0d want 0", cnt_rf + cnt_testa + cnt_pc + cnt_ir);
    end
    load(8'h44);                    // from IDLE only the low byte changes
    tests++;
    if (wr_data !== 16'h0244 || err !== 1'b1) begin
      fails++; $display("FAIL err_idle wr_data=%h err=%b want 0244/1", wr_data, err);
    end
    do_abort();
    tests++;
    if (err !== 1'b0 || wr_data !== 16'h0000) begin
      fails++; $display("FAIL err_abort_clear err=%b wr_data=%h want 0/0000", err, wr_data);
    end
    load(8'h66);
    do_commit(2'b00, 4'h1);
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL err_half err=%b busy=%b want 1/0", err, busy);
    end
    load(8'h77);
    tests++;
    if (wr_data !== 16'h7766) begin
      fails++; $display("FAIL err_stay_half wr_data=%h want 7766", wr_data);
    end
    do_abort();
  endtask

  task automatic test_ld_commit();
    load(8'h0D);
    load(8'hF0);
    reg_data = 16'hF00D; cpu_busy = 1'b0;
    clr_cnt();
    sw_data = 8'h99; ld_byte = 1'b1; sel = 2'b01; reg_sel = 4'b0100; commit = 1'b1;
    step();
    ld_byte = 1'b0; commit = 1'b0;
    tests++;
    if (wr_data !== 16'hF00D || busy !== 1'b1) begin
      fails++; $display("FAIL ldc_commit_wins wr_data=%h busy=%b want f00d/1", wr_data, busy);
    end
    step();
    tests++;
    if ({rf_we, testa_we, pc_we, ir_we} !== 4'b0100) begin
      fails++; $display("FAIL ldc_testa strobes=%b want 0100", {rf_we, testa_we, pc_we, ir_we});
    end
    step(); step(); step();
  endtask

  task automatic test_wrap_abort();
    load(8'h11); load(8'h22); load(8'h33);
    tests++;
    if (wr_data !== 16'h0033) begin
      fails++; $display("FAIL wrap wr_data=%h want 0033", wr_data);
    end
    load(8'h44);
    cpu_busy = 1'b1;
    clr_cnt();
    do_commit(2'b11, 4'b1111);
    load(8'h55);                    // ignored while pending
    tests++;
    if (wr_data !== 16'h4433 || busy !== 1'b1) begin
      fails++; $display("FAIL pend_ld_ignored wr_data=%h busy=%b want 4433/1", wr_data, busy);
    end
    cpu_busy = 1'b0;
    do_abort();
    tests++;
    if (wr_data !== 16'h0000 || busy !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL abort_pend wr_data=%h busy=%b err=%b want 0000/0/0", wr_data, busy, err);
    end
    step(); step(); step();
    tests++;
    if (cnt_rf + cnt_testa + cnt_pc + cnt_ir !== 0) begin
      fails++; $display("FAIL abort_nostrobe strobes=%0d want 0", cnt_rf + cnt_testa + cnt_pc + cnt_ir);
    end
  endtask

  task automatic test_verify();
    load(8'h5A); load(8'h5A);
    reg_data = 16'hFFFF; cpu_busy = 1'b0;
    do_commit(2'b11, 4'b1111);
    step();
    tests++;
    if (ir_we !== 1'b1) begin
      fails++; $display("FAIL vfy_ir_strobe ir_we=%b want 1", ir_we);
    end
    step();
    tests++;
    if (busy !== VERIFY_ON) begin
      fails++; $display("FAIL vfy_hold busy=%b want %b", busy, VERIFY_ON);
    end
    step();
    tests++;
    if (verify_fail !== VERIFY_ON || busy !== 1'b0) begin
      fails++; $display("FAIL vfy_mismatch verify_fail=%b busy=%b want %b/0", verify_fail, busy, VERIFY_ON);
    end
    load(8'h5A); load(8'h5A);
    reg_data = 16'h5A5A;
    do_commit(2'b11, 4'b1111);
    tests++;
    if (verify_fail !== 1'b0) begin
      fails++; $display("FAIL vfy_clear_on_commit verify_fail=%b want 0", verify_fail);
    end
    step(); step(); step(); step();
    tests++;
    if (verify_fail !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL vfy_match verify_fail=%b busy=%b want 0/0", verify_fail, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = '0; reg_sel = '0; sw_data = '0; ld_byte = 1'b0;
    commit = 1'b0; abort = 1'b0; cpu_busy = 1'b0; reg_data = '0;
    clr_cnt();
    test_reset();
    test_rf_write();
    test_pc_wait();
    test_err();
    test_ld_commit();
    test_wrap_abort();
    test_verify();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $fatal(1, "watchdog");
  end

endmodule
